alu_issue_queue: RTL
====================

Name: alu_issue_queue

Overview:
- Reservation station directly upstream of the 3-lane ALU.
- Buffers dispatched ALU ops (opcode/func3/func7, operands, immediate, dest phys reg) and wakes operands by snooping the ALU result broadcast.
- Issues up to one ready op per free ALU lane per cycle, oldest first.
- Sits between rename/dispatch and the ALU. Result broadcast comes from the ALU outputs: data and dest tag per lane.

Parameters:
- DEPTH, 8, number of queue entries (power of 2, 4..16)
- NUM_FU, 3, ALU lanes fed and result broadcast ports snooped
- PREG_W, 6, physical register tag width
- XLEN, 32, data width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all entries (mispredict)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept this cycle
- disp_opcode  in  7  RISC-V opcode
- disp_func3  in  3  func3
- disp_func7  in  7  func7
- disp_src1_tag / disp_src2_tag  in  PREG_W each  source phys tags
- disp_src1_rdy / disp_src2_rdy  in  1 each  operand value already valid
- disp_src1_val / disp_src2_val  in  XLEN each  operand values (meaningful when rdy)
- disp_imm  in  XLEN  sign-extended immediate
- disp_dr  in  PREG_W  dest phys tag
- wb_valid  in  NUM_FU  result broadcast valid per lane
- wb_tag  in  NUM_FU*PREG_W  broadcast dest tags
- wb_data  in  NUM_FU*XLEN  broadcast results
- fu_ready  in  NUM_FU  lane k can take an op next cycle
- iss_valid  out  NUM_FU  issue strobe per lane
- iss_opcode / iss_func3 / iss_func7  out  NUM_FU*7 / *3 / *7  decoded fields per lane
- iss_sr1 / iss_sr2 / iss_imm  out  NUM_FU*XLEN each  operands per lane
- iss_dr  out  NUM_FU*PREG_W  dest tag per lane
- occupancy  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset: on the rising edge with rst=1, all entries are invalidated and every output register is cleared to 0 (iss_*, occupancy). disp_ready reads 1 after reset.
- rst dominates flush; flush dominates dispatch, wakeup and issue.
- Reset or flush mid-operation discards in-flight issue selections. iss_valid is 0 in the following cycle.
- Dispatch:
  - disp_ready = (occupancy < DEPTH), computed from registered occupancy only; same-cycle frees do not count.
  - On disp_valid & disp_ready, the entry is written into the lowest-index free slot and stamped youngest in the age matrix.
  - disp_valid while not ready is ignored; no entry is written.
- Dispatch bypass: if wb_valid[k] and wb_tag[k] matches a non-ready dispatching source in the same cycle, the entry is written with rdy=1 and val=wb_data[k].
- Wakeup:
  - Each cycle, every valid entry whose src tag is not ready and equals wb_tag[k] with wb_valid[k] captures wb_data[k] and sets rdy.
  - If several lanes match, the lowest k wins.
  - Broadcasts with tag 0 are ignored.
- Eligibility: an entry is eligible when valid, src1_rdy and src2_rdy are all set. It must have been eligible at the start of the cycle; there is no same-cycle wakeup-to-select.
- The dispatcher marks unused operands ready (src2 for I/U-type, src1 for LUI). The queue does not decode operand usage.
- Select: each cycle, take the eligible entries in age order (oldest first). Walk lanes k=0..NUM_FU-1, assigning the next-oldest entry to each lane with fu_ready[k]=1. Lanes with fu_ready=0 get nothing.
- Issue:
  - Selected entries are freed at the same edge, and their fields are registered onto iss_* for lane k with iss_valid[k]=1.
  - Each iss_valid pulse lasts exactly one cycle.
  - Unassigned lanes drive iss_valid=0 and hold their previous payload.
- Latency: an op dispatched in cycle c with both sources ready shows iss_valid in cycle c+2 (minimum). An op woken by a broadcast in cycle c shows iss_valid no earlier than c+2.
- Simultaneous free and dispatch in one cycle is legal. occupancy_next = occupancy + accepted_dispatch - num_issued.
- Full queue: disp_ready=0 until at least one issue has registered.
- Empty queue: iss_valid is all 0.
- An entry issues exactly once and is never duplicated across lanes.

Decomposition:
- Shared package riscv_ooo_pkg holds:
  - the opcode constants (OP_RTYPE 7'b0110011, OP_ITYPE 7'b0010011, OP_LUI 7'b0110111, OP_LOAD 7'b0000011)
  - PREG_W and XLEN localparams
  - the packed struct iq_entry_t {valid, opcode, func3, func7, src1_tag, src1_rdy, src1_val, src2_tag, src2_rdy, src2_val, imm, dr}
- One sub-module, alu_iq_select:
  - Inputs: DEPTH x DEPTH age matrix, eligibility vector, fu_ready.
  - Outputs: NUM_FU one-hot grant vectors.
  - Updates the age matrix on dispatch and on free.

Test Plan:
- Reset, then dispatch an ADD with both sources ready (src1=5, src2=7, dr=10), all fu_ready=1 -> iss_valid=3'b001 two cycles later with iss_sr1=5, iss_sr2=7, iss_dr=10; occupancy returns to 0.
- Dispatch XOR with src1 tag 12 not ready; then wb_valid[1]=1, wb_tag[1]=12, wb_data[1]=0xA5 -> lane 0 issues sr1=0xA5 two cycles after the broadcast, and not earlier.
- Fill 8 entries all not ready -> disp_ready=0 and a 9th disp_valid is dropped. Wake all 8 at once -> issues of 3, 3, 2 on consecutive cycles, oldest first (dispatch order 0..7).
- fu_ready=3'b010 with 3 eligible entries -> only lane 1 issues the oldest, one entry per cycle.
- A dispatch whose src2 tag matches a same-cycle broadcast (tag 20, data 0x1234) -> the entry issues with sr2=0x1234 and no hang.
- flush with 5 entries, then rst while an iss_valid pulse is pending -> iss_valid=0 next cycle, occupancy=0, disp_ready=1.

Source files
------------

// File: rtl/riscv_ooo_pkg.sv
// Shared types and constants for the out-of-order ALU issue path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package riscv_ooo_pkg;

   localparam int PREG_W = 6;
   localparam int XLEN   = 32;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;

   typedef struct packed {
      logic              valid;
      logic [6:0]        opcode;
      logic [2:0]        func3;
      logic [6:0]        func7;
      logic [PREG_W-1:0] src1_tag;
      logic              src1_rdy;
      logic [XLEN-1:0]   src1_val;
      logic [PREG_W-1:0] src2_tag;
      logic              src2_rdy;
      logic [XLEN-1:0]   src2_val;
      logic [XLEN-1:0]   imm;
      logic [PREG_W-1:0] dr;
   } iq_entry_t;

endpackage

// File: rtl/alu_iq_select.sv
// Age-ordered picker: grants the oldest eligible entries to ready ALU lanes.
// Latency: grants are combinational from registered age/eligibility; age matrix updates on the clock edge.
// Backpressure: a lane with fu_ready_i=0 gets no grant; leftover entries wait for a later cycle.
module alu_iq_select #(
   parameter int DEPTH  = 8,
   parameter int NUM_FU = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DEPTH-1:0]             elig_i,
   input  logic [NUM_FU-1:0]            fu_ready_i,
   input  logic                         disp_we_i,
   input  logic [DEPTH-1:0]             disp_slot_i,
   output logic [NUM_FU-1:0][DEPTH-1:0] grant_o,
   output logic [DEPTH-1:0]             free_o
);

   // age_q[i][j] = 1 means entry i is older than entry j
   logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

   // walk lanes in order, each ready lane takes the oldest entry not yet granted
   always_comb begin
      logic [DEPTH-1:0] rem;
      logic             older;
      rem     = elig_i;
      older   = 1'b0;
      grant_o = '0;
      free_o  = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         if (fu_ready_i[k]) begin
            for (int i = 0; i < DEPTH; i++) begin
               older = 1'b0;
               for (int j = 0; j < DEPTH; j++) begin
                  older = older | (rem[j] & age_q[j][i]);
               end
               grant_o[k][i] = rem[i] & ~older;
            end
            rem = rem & ~grant_o[k];
         end
         free_o = free_o | grant_o[k];
      end
   end

   // freed entries stop being older than anyone; a new entry is younger than everything
   always_comb begin
      age_d = age_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (free_o[i]) age_d[i] = '0;
      end
      if (disp_we_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (disp_slot_i[i]) begin
               age_d[i] = '0;
               for (int j = 0; j < DEPTH; j++) begin
                  if (j != i) age_d[j][i] = 1'b1;
               end
            end
         end
      end
   end

   // age matrix register
   always_ff @(posedge clk) begin
      if (rst) age_q <= '0;
      else     age_q <= age_d;
   end

endmodule

// File: rtl/alu_issue_queue.sv
// Reservation station in front of the ALU lanes: buffers ops, snoops result broadcasts, issues oldest-first.
// Latency: dispatch-to-issue and wakeup-to-issue are both 2 cycles minimum; issue payload is registered.
// Backpressure: disp_ready drops when the registered occupancy reaches DEPTH; per-lane fu_ready gates issue.
module alu_issue_queue
   import riscv_ooo_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int NUM_FU = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic [6:0]               disp_opcode,
   input  logic [2:0]               disp_func3,
   input  logic [6:0]               disp_func7,
   input  logic [PREG_W-1:0]        disp_src1_tag,
   input  logic [PREG_W-1:0]        disp_src2_tag,
   input  logic                     disp_src1_rdy,
   input  logic                     disp_src2_rdy,
   input  logic [XLEN-1:0]          disp_src1_val,
   input  logic [XLEN-1:0]          disp_src2_val,
   input  logic [XLEN-1:0]          disp_imm,
   input  logic [PREG_W-1:0]        disp_dr,
   input  logic [NUM_FU-1:0]        wb_valid,
   input  logic [NUM_FU*PREG_W-1:0] wb_tag,
   input  logic [NUM_FU*XLEN-1:0]   wb_data,
   input  logic [NUM_FU-1:0]        fu_ready,
   output logic [NUM_FU-1:0]        iss_valid,
   output logic [NUM_FU*7-1:0]      iss_opcode,
   output logic [NUM_FU*3-1:0]      iss_func3,
   output logic [NUM_FU*7-1:0]      iss_func7,
   output logic [NUM_FU*XLEN-1:0]   iss_sr1,
   output logic [NUM_FU*XLEN-1:0]   iss_sr2,
   output logic [NUM_FU*XLEN-1:0]   iss_imm,
   output logic [NUM_FU*PREG_W-1:0] iss_dr,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int OCC_W = $clog2(DEPTH) + 1;

   iq_entry_t                     ent_q [DEPTH];
   iq_entry_t                     ent_d [DEPTH];
   logic [OCC_W-1:0]              occ_q, occ_d;
   logic [NUM_FU-1:0]             iss_valid_q, iss_valid_d;
   logic [NUM_FU*7-1:0]           iss_opcode_q, iss_opcode_d, iss_func7_q, iss_func7_d;
   logic [NUM_FU*3-1:0]           iss_func3_q, iss_func3_d;
   logic [NUM_FU*XLEN-1:0]        iss_sr1_q, iss_sr1_d, iss_sr2_q, iss_sr2_d, iss_imm_q, iss_imm_d;
   logic [NUM_FU*PREG_W-1:0]      iss_dr_q, iss_dr_d;
   logic [DEPTH-1:0]              elig, disp_slot, free_vec;
   logic [NUM_FU-1:0]             sel_fu_ready;
   logic [NUM_FU-1:0][DEPTH-1:0]  grant;
   logic                          disp_we;

   // {rdy, val} after snooping the broadcast; the lowest matching lane wins, tag 0 never matches
   function automatic logic [XLEN:0] snoop(input logic [PREG_W-1:0] tag, input logic rdy,
                                           input logic [XLEN-1:0] val);
      logic [XLEN:0] r;
      r = {rdy, val};
      for (int k = NUM_FU - 1; k >= 0; k--) begin
         if (!rdy && wb_valid[k] && wb_tag[k*PREG_W +: PREG_W] != '0 &&
             wb_tag[k*PREG_W +: PREG_W] == tag)
            r = {1'b1, wb_data[k*XLEN +: XLEN]};
      end
      return r;
   endfunction

   assign disp_ready   = (occ_q < OCC_W'(DEPTH));
   assign disp_we      = disp_valid & disp_ready & ~flush;
   assign sel_fu_ready = flush ? '0 : fu_ready;

   // eligibility from registered state only, and the lowest-index free slot
   always_comb begin
      elig      = '0;
      disp_slot = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         elig[i] = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
         if (!ent_q[i].valid) begin
            disp_slot    = '0;
            disp_slot[i] = 1'b1;
         end
      end
   end

   alu_iq_select #(.DEPTH(DEPTH), .NUM_FU(NUM_FU)) u_select (
      .clk         (clk),
      .rst         (rst),
      .elig_i      (elig),
      .fu_ready_i  (sel_fu_ready),
      .disp_we_i   (disp_we),
      .disp_slot_i (disp_slot),
      .grant_o     (grant),
      .free_o      (free_vec)
   );

   // next state: issue payload, wakeup, free, dispatch with bypass, occupancy; flush overrides
   always_comb begin
      iq_entry_t     nw;
      logic [XLEN:0] s;
      int            n_iss;
      n_iss        = 0;
      nw           = '0;
      s            = '0;
      iss_valid_d  = '0;
      iss_opcode_d = iss_opcode_q;
      iss_func3_d  = iss_func3_q;
      iss_func7_d  = iss_func7_q;
      iss_sr1_d    = iss_sr1_q;
      iss_sr2_d    = iss_sr2_q;
      iss_imm_d    = iss_imm_q;
      iss_dr_d     = iss_dr_q;
      for (int k = 0; k < NUM_FU; k++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (grant[k][i]) begin
               iss_valid_d[k]                = 1'b1;
               iss_opcode_d[k*7 +: 7]        = ent_q[i].opcode;
               iss_func3_d[k*3 +: 3]         = ent_q[i].func3;
               iss_func7_d[k*7 +: 7]         = ent_q[i].func7;
               iss_sr1_d[k*XLEN +: XLEN]     = ent_q[i].src1_val;
               iss_sr2_d[k*XLEN +: XLEN]     = ent_q[i].src2_val;
               iss_imm_d[k*XLEN +: XLEN]     = ent_q[i].imm;
               iss_dr_d[k*PREG_W +: PREG_W]  = ent_q[i].dr;
            end
         end
         n_iss = n_iss + int'(iss_valid_d[k]);
      end
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         s = snoop(ent_q[i].src1_tag, ent_q[i].src1_rdy, ent_q[i].src1_val);
         {ent_d[i].src1_rdy, ent_d[i].src1_val} = s;
         s = snoop(ent_q[i].src2_tag, ent_q[i].src2_rdy, ent_q[i].src2_val);
         {ent_d[i].src2_rdy, ent_d[i].src2_val} = s;
         if (free_vec[i]) ent_d[i].valid = 1'b0;
      end
      nw.valid    = 1'b1;
      nw.opcode   = disp_opcode;
      nw.func3    = disp_func3;
      nw.func7    = disp_func7;
      nw.src1_tag = disp_src1_tag;
      nw.src2_tag = disp_src2_tag;
      nw.imm      = disp_imm;
      nw.dr       = disp_dr;
      s = snoop(disp_src1_tag, disp_src1_rdy, disp_src1_val);
      {nw.src1_rdy, nw.src1_val} = s;
      s = snoop(disp_src2_tag, disp_src2_rdy, disp_src2_val);
      {nw.src2_rdy, nw.src2_val} = s;
      if (disp_we) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (disp_slot[i]) ent_d[i] = nw;
         end
      end
      occ_d = occ_q + OCC_W'(disp_we) - OCC_W'(n_iss);
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
         occ_d       = '0;
         iss_valid_d = '0;
      end
   end

   // entry storage and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         occ_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         occ_q <= occ_d;
      end
   end

   // issue output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_valid_q  <= '0;
         iss_opcode_q <= '0;
         iss_func3_q  <= '0;
         iss_func7_q  <= '0;
         iss_sr1_q    <= '0;
         iss_sr2_q    <= '0;
         iss_imm_q    <= '0;
         iss_dr_q     <= '0;
      end else begin
         iss_valid_q  <= iss_valid_d;
         iss_opcode_q <= iss_opcode_d;
         iss_func3_q  <= iss_func3_d;
         iss_func7_q  <= iss_func7_d;
         iss_sr1_q    <= iss_sr1_d;
         iss_sr2_q    <= iss_sr2_d;
         iss_imm_q    <= iss_imm_d;
         iss_dr_q     <= iss_dr_d;
      end
   end

   assign iss_valid  = iss_valid_q;
   assign iss_opcode = iss_opcode_q;
   assign iss_func3  = iss_func3_q;
   assign iss_func7  = iss_func7_q;
   assign iss_sr1    = iss_sr1_q;
   assign iss_sr2    = iss_sr2_q;
   assign iss_imm    = iss_imm_q;
   assign iss_dr     = iss_dr_q;
   assign occupancy  = occ_q;

endmodule
